// File: rtl/multiplier_repetitive_addition.sv
// multiplier_repetitive_addition: sequential unsigned multiply by repeated addition, start/busy/done handshake.
// Define OPERAND_SWAP_EN to iterate over the smaller operand.
module multiplier_repetitive_addition #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, cnt_q, cnt_d, a_ld, cnt_ld;
  logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
`ifdef OPERAND_SWAP_EN
  logic swap;
  // ties keep the multiplier as the count
  assign swap   = multiplicand < multiplier;
  assign cnt_ld = swap ? multiplicand : multiplier;
  assign a_ld   = swap ? multiplier : multiplicand;
`else
  assign cnt_ld = multiplier;
  assign a_ld   = multiplicand;
`endif
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    product_d = product_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        a_d     = a_ld;
        cnt_d   = cnt_ld;
        acc_d   = '0;
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      if (cnt_q != '0) begin
        acc_d = acc_q + {{WIDTH{1'b0}}, a_q};
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        product_d = acc_q;
        state_d   = S_DONE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end
  assign ready   = state_q == S_IDLE;
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign product = product_q;
endmodule

// File: tb/tb_multiplier_repetitive_addition.sv
// tb_multiplier_repetitive_addition: table-driven vectors with a scoreboard queue plus handshake/reset corner cases.
module tb_multiplier_repetitive_addition;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]  mc = '0, mp = '0;
  logic        ready, busy, done;
  logic [15:0] product;
  int checks = 0, errors = 0;
  logic [15:0] last_prod = '0;
  typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] p;} vec_t;
  typedef struct {logic [15:0] p; int edges;} exp_t;
  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  multiplier_repetitive_addition #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc), .multiplier(mp),
    .ready(ready), .busy(busy), .done(done), .product(product)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // edges counted from the accept edge (edge 1) to the edge after which done is seen high
  function automatic int lat(input logic [7:0] a, input logic [7:0] b);
`ifdef OPERAND_SWAP_EN
    return int'((a < b) ? a : b) + 2;
`else
    return int'(b) + 2;
`endif
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                       input bit hammer, input string name);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      errors++;
      checks++;
      $display("FAIL %s ready timeout: got 0 expected 1", name);
    end
    mc = a;
    mp = b;
    start = 1'b1;
    sb.push_back('{p, lat(a, b)});
    @(posedge clk);
    #1;
    n = 1;
    chk({name, " busy"}, 32'(busy), 32'd1);
    chk({name, " product held"}, 32'(product), 32'(last_prod));
    while (!done && n < 600) begin
      @(negedge clk);
      if (hammer) begin
        mc = 8'($urandom);
        mp = 8'($urandom);
      end else start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " product"}, 32'(product), 32'(e.p));
    chk({name, " latency"}, 32'(n), 32'(e.edges));
    last_prod = e.p;
    @(negedge clk);
    if (hammer) begin
      mc = 8'($urandom);
      mp = 8'($urandom);
    end
    @(posedge clk);
    #1;
    chk({name, " done pulse"}, 32'(done), 32'd0);
    chk({name, " ready back"}, 32'(ready), 32'd1);
    chk({name, " product kept"}, 32'(product), 32'(e.p));
    start = 1'b0;
  endtask

  initial begin
    int seen;
    vecs[0] = '{8'd13, 8'd11, 16'd143};
    vecs[1] = '{8'd0, 8'd200, 16'd0};
    vecs[2] = '{8'd200, 8'd0, 16'd0};
    vecs[3] = '{8'd255, 8'd255, 16'hFE01};
    vecs[4] = '{8'd200, 8'd3, 16'd600};
    vecs[5] = '{8'd3, 8'd200, 16'd600};
    #12;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, $sformatf("vec%0d", i));
    do_op(8'd7, 8'd5, 16'd35, 1'b1, "hammer");
    do_op(8'd9, 8'd6, 16'd54, 1'b0, "back2back");
    @(negedge clk);
    mc = 8'd50;
    mp = 8'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort product", 32'(product), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = '0;
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort no done", 32'(seen), 32'd0);
    do_op(8'd3, 8'd4, 16'd12, 1'b0, "after reset");
    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
